// File: rtl/race_sequencer.sv
// race_sequencer: top-level race controller for the two-player racing game.
//
// Sequences IDLE -> COUNTDOWN -> RACE -> FINISH -> IDLE and produces the
// 3-bit game state that both physics engines consume. The engines only
// integrate motion while game_state == 3'd4. Race time is kept on a 60 Hz
// game tick derived from the system clock.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   start_btn   in   start request (level, already synchronized)
//   p1_finish   in   player-1 engine finish (level)
//   p2_finish   in   player-2 engine finish (level)
//   pause_btn   in   pause toggle (level), only when RACE_PAUSE_EN is defined
//   game_state  out  0 IDLE, 2 COUNTDOWN, 4 RACE, 5 FINISH, 7 PAUSE
//   engine_rst  out  one-cycle pulse resetting both engines at race start
//   countdown   out  countdown digit for display
//   winner      out  0 none/timeout, 1 P1, 2 P2, 3 tie
//   timeout     out  last race ended by MAX_RACE_TICKS
//   race_time   out  race ticks elapsed, saturating
//   tick        out  one-cycle 60 Hz strobe
//
// Build option: define RACE_PAUSE_EN to add pause_btn and the PAUSE state.

module race_sequencer #(
  parameter int          CLK_FREQ       = 100_000_000,
  parameter int          TICKS_PER_SEC  = 60,
  parameter int          COUNT_SECS     = 3,
  parameter logic [15:0] MAX_RACE_TICKS = 16'd36000,
  parameter int          RESULT_TICKS   = 180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        p1_finish,
  input  logic        p2_finish,
`ifdef RACE_PAUSE_EN
  input  logic        pause_btn,
`endif
  output logic [2:0]  game_state,
  output logic        engine_rst,
  output logic [1:0]  countdown,
  output logic [1:0]  winner,
  output logic        timeout,
  output logic [15:0] race_time,
  output logic        tick
);

  localparam int          TICK_PERIOD = CLK_FREQ / 60;
  localparam int          TW          = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_PERIOD - 1);
  localparam logic [15:0] SEC_MAX     = 16'(TICKS_PER_SEC - 1);
  localparam logic [15:0] RES_MAX     = 16'(RESULT_TICKS - 1);
  localparam logic [1:0]  CNT_INIT    = 2'(COUNT_SECS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd2,
    S_RACE   = 3'd4,
    S_FINISH = 3'd5,
    S_PAUSE  = 3'd7
  } state_t;

  state_t        r_state, w_next_state;
  logic [TW-1:0] r_tick_cnt;
  logic          r_start_d, r_p1_d, r_p2_d;
  logic          r_armed;
  logic [15:0]   r_step_cnt, w_step_cnt;
  logic          r_engine_rst, w_engine_rst;
  logic [1:0]    r_countdown, w_countdown;
  logic [1:0]    r_winner, w_winner;
  logic          r_timeout, w_timeout;
  logic [15:0]   r_race_time, w_race_time, w_race_inc;
  logic          w_tick, w_start_edge, w_p1_edge, w_p2_edge;
`ifdef RACE_PAUSE_EN
  logic          r_pause_d, w_pause_edge;
`endif

  assign w_tick = (r_tick_cnt == TICK_MAX);

  // r_armed masks the first cycle after reset: the delay registers are cleared
  // by reset, so without it an input held high through reset would look like
  // a fresh rising edge.
  assign w_start_edge = r_armed & start_btn & ~r_start_d;
  assign w_p1_edge    = r_armed & p1_finish & ~r_p1_d;
  assign w_p2_edge    = r_armed & p2_finish & ~r_p2_d;
`ifdef RACE_PAUSE_EN
  assign w_pause_edge = r_armed & pause_btn & ~r_pause_d;
`endif

  assign w_race_inc = (r_race_time == 16'hFFFF) ? r_race_time : r_race_time + 16'd1;

  always_comb begin
    w_next_state = r_state;
    w_step_cnt   = r_step_cnt;
    w_engine_rst = 1'b0;
    w_countdown  = r_countdown;
    w_winner     = r_winner;
    w_timeout    = r_timeout;
    w_race_time  = r_race_time;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_next_state = S_COUNT;
          w_engine_rst = 1'b1;
          w_countdown  = CNT_INIT;
          w_winner     = 2'd0;
          w_timeout    = 1'b0;
          w_race_time  = 16'd0;
          w_step_cnt   = 16'd0;
        end
      end
      S_COUNT: begin
        if (w_tick) begin
          if (r_step_cnt == SEC_MAX) begin
            w_step_cnt  = 16'd0;
            w_countdown = r_countdown - 2'd1;
            if (r_countdown == 2'd1) w_next_state = S_RACE;
          end else begin
            w_step_cnt = r_step_cnt + 16'd1;
          end
        end
      end
      S_RACE: begin
        if (w_tick) w_race_time = w_race_inc;
        // A finish edge outranks a timeout landing on the same tick.
        if (w_p1_edge | w_p2_edge) begin
          w_winner     = {w_p2_edge, w_p1_edge};
          w_next_state = S_FINISH;
          w_step_cnt   = 16'd0;
        end else if (w_tick && (w_race_inc == MAX_RACE_TICKS)) begin
          w_winner     = 2'd0;
          w_timeout    = 1'b1;
          w_next_state = S_FINISH;
          w_step_cnt   = 16'd0;
        end
`ifdef RACE_PAUSE_EN
        else if (w_pause_edge) begin
          w_next_state = S_PAUSE;
        end
`endif
      end
      S_FINISH: begin
        if (w_tick) begin
          if (r_step_cnt == RES_MAX) w_next_state = S_IDLE;
          else                       w_step_cnt   = r_step_cnt + 16'd1;
        end
      end
`ifdef RACE_PAUSE_EN
      S_PAUSE: begin
        if (w_pause_edge) w_next_state = S_RACE;
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_start_d    <= 1'b0;
      r_p1_d       <= 1'b0;
      r_p2_d       <= 1'b0;
      r_armed      <= 1'b0;
      r_step_cnt   <= 16'd0;
      r_engine_rst <= 1'b0;
      r_countdown  <= 2'd0;
      r_winner     <= 2'd0;
      r_timeout    <= 1'b0;
      r_race_time  <= 16'd0;
`ifdef RACE_PAUSE_EN
      r_pause_d    <= 1'b0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_start_d    <= start_btn;
      r_p1_d       <= p1_finish;
      r_p2_d       <= p2_finish;
      r_armed      <= 1'b1;
      r_step_cnt   <= w_step_cnt;
      r_engine_rst <= w_engine_rst;
      r_countdown  <= w_countdown;
      r_winner     <= w_winner;
      r_timeout    <= w_timeout;
      r_race_time  <= w_race_time;
`ifdef RACE_PAUSE_EN
      r_pause_d    <= pause_btn;
`endif
    end
  end

  assign game_state = r_state;
  assign engine_rst = r_engine_rst;
  assign countdown  = r_countdown;
  assign winner     = r_winner;
  assign timeout    = r_timeout;
  assign race_time  = r_race_time;
  assign tick       = w_tick;

endmodule

// File: tb/tb_race_sequencer.sv
// tb_race_sequencer: directed bench for race_sequencer with a 10-cycle tick,
// 4 ticks per countdown step, 50-tick timeout and 5-tick result display.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_race_sequencer;
  logic        clk = 1'b0;
  logic        rst, start_btn, p1_finish, p2_finish;
`ifdef RACE_PAUSE_EN
  logic        pause_btn;
`endif
  logic [2:0]  game_state;
  logic        engine_rst;
  logic [1:0]  countdown, winner;
  logic        timeout;
  logic [15:0] race_time;
  logic        tick;

  int n_vec = 0;
  int n_err = 0;

  race_sequencer #(
    .CLK_FREQ(600), .TICKS_PER_SEC(4), .COUNT_SECS(3),
    .MAX_RACE_TICKS(16'd50), .RESULT_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn),
    .p1_finish(p1_finish), .p2_finish(p2_finish),
`ifdef RACE_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .game_state(game_state), .engine_rst(engine_rst), .countdown(countdown),
    .winner(winner), .timeout(timeout), .race_time(race_time), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stay on a falling edge where tick is high (bounded).
  task automatic wait_tick_hi();
    for (int i = 0; i < 20 && tick !== 1'b1; i++) @(negedge clk);
    if (tick !== 1'b1) chk("tick_wait_expired", 0, 1);
  endtask

  // Advance past one tick edge; outputs then show that tick's effect.
  task automatic tick_edge();
    wait_tick_hi();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_edge();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  game_state, 0);
    chk({tag, "_erst"},   engine_rst, 0);
    chk({tag, "_cd"},     countdown,  0);
    chk({tag, "_winner"}, winner,     0);
    chk({tag, "_tmo"},    timeout,    0);
    chk({tag, "_rtime"},  race_time,  0);
    chk({tag, "_tick"},   tick,       0);
  endtask

  // From IDLE with start_btn low: press start and run the full countdown.
  task automatic start_race();
    start_btn = 1'b1;
    @(negedge clk);
    chk("sr_state_cd", game_state, 2);
    chk("sr_erst_hi",  engine_rst, 1);
    chk("sr_tmo_clr",  timeout,    0);
    start_btn = 1'b0;
    @(negedge clk);
    chk("sr_erst_lo",  engine_rst, 0);
    ticks(12);
    chk("sr_state_race", game_state, 4);
  endtask

  initial begin
    int c;
    rst = 1'b1; start_btn = 1'b1; p1_finish = 1'b0; p2_finish = 1'b0;
`ifdef RACE_PAUSE_EN
    pause_btn = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // 1: start held through reset is not a press
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_start_idle", game_state, 0);
    start_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("release_idle", game_state, 0);

    wait_tick_hi();
    c = 0;
    do begin @(negedge clk); c++; end while (tick !== 1'b1 && c < 40);
    chk("tick_period", c, 10);

    start_btn = 1'b1;
    @(negedge clk);
    chk("t1_state_cd", game_state, 2);
    chk("t1_erst_hi",  engine_rst, 1);
    chk("t1_cd_init",  countdown,  3);
    start_btn = 1'b0;
    @(negedge clk);
    chk("t1_erst_lo", engine_rst, 0);
    for (int i = 1; i <= 12; i++) begin
      tick_edge();
      chk($sformatf("t1_cd_%0d", i),    countdown,  3 - i / 4);
      chk($sformatf("t1_state_%0d", i), game_state, (i < 12) ? 2 : 4);
    end

    // 2: P1 wins after 20 ticks
    ticks(20);
    chk("t2_rtime20", race_time, 20);
    p1_finish = 1'b1;
    @(negedge clk);
    chk("t2_state_fin", game_state, 5);
    chk("t2_winner",    winner,     1);
    chk("t2_rtime",     race_time,  20);
    chk("t2_tmo",       timeout,    0);
    ticks(4);
    chk("t2_still_fin", game_state, 5);
    tick_edge();
    chk("t2_idle",        game_state, 0);
    chk("t2_winner_hold", winner,     1);
    chk("t2_rtime_hold",  race_time,  20);
    p1_finish = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    chk("t2_win_clr",   winner,     0);
    chk("t2_rtime_clr", race_time,  0);
    chk("t2_state_cd",  game_state, 2);
    start_btn = 1'b0;

    // 3: p2 already high entering RACE is no edge; then a tie
    @(negedge clk);
    ticks(6);
    p2_finish = 1'b1;
    ticks(6);
    chk("t3_state_race", game_state, 4);
    ticks(3);
    chk("t3_no_fin",  game_state, 4);
    chk("t3_no_win",  winner,     0);
    chk("t3_rtime3",  race_time,  3);
    p2_finish = 1'b0;
    @(negedge clk);
    p1_finish = 1'b1; p2_finish = 1'b1;
    @(negedge clk);
    chk("t3_tie",       winner,     3);
    chk("t3_state_fin", game_state, 5);
    ticks(5);
    chk("t3_idle", game_state, 0);
    p1_finish = 1'b0; p2_finish = 1'b0;
    @(negedge clk);

    // 4: timeout, then finish edge on the timeout tick
    start_race();
    ticks(49);
    chk("t4_state49", game_state, 4);
    chk("t4_rtime49", race_time,  49);
    tick_edge();
    chk("t4_state_fin", game_state, 5);
    chk("t4_winner0",   winner,     0);
    chk("t4_tmo",       timeout,    1);
    chk("t4_rtime50",   race_time,  50);
    ticks(5);
    chk("t4_idle",     game_state, 0);
    chk("t4_tmo_hold", timeout,    1);
    start_race();
    ticks(49);
    wait_tick_hi();
    p2_finish = 1'b1;
    @(negedge clk);
    chk("t4b_winner2", winner,     2);
    chk("t4b_tmo0",    timeout,    0);
    chk("t4b_state",   game_state, 5);
    chk("t4b_rtime",   race_time,  50);
    ticks(5);
    p2_finish = 1'b0;
    @(negedge clk);

    // 5: reset mid-countdown and mid-race; start ignored in RACE
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    ticks(5);
    chk("t5_cd_mid", countdown, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("t5_rst_cd");
    @(negedge clk);
    start_race();
    ticks(5);
    start_btn = 1'b1;
    @(negedge clk);
    chk("t5_start_ign", game_state, 4);
    chk("t5_no_erst",   engine_rst, 0);
    start_btn = 1'b0;
    tick_edge();
    chk("t5_rtime6", race_time, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("t5_rst_race");
    @(negedge clk);

`ifdef RACE_PAUSE_EN
    // 6: pause freezes race time and ignores finish
    start_race();
    ticks(10);
    pause_btn = 1'b1;
    @(negedge clk);
    chk("t6_paused", game_state, 7);
    pause_btn = 1'b0;
    ticks(30);
    chk("t6_rtime_frozen", race_time, 10);
    p1_finish = 1'b1;
    @(negedge clk);
    chk("t6_fin_ign_state", game_state, 7);
    chk("t6_fin_ign_win",   winner,     0);
    p1_finish = 1'b0;
    @(negedge clk);
    pause_btn = 1'b1;
    @(negedge clk);
    chk("t6_resumed", game_state, 4);
    pause_btn = 1'b0;
    tick_edge();
    chk("t6_rtime11", race_time, 11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
